// File: rtl/exec_core_param.sv
// exec_core_param: multi-cycle command executor that owns the register file,
// the data RAM and the compare flags. It takes one decoded command at a time
// and runs it through IDLE -> EXEC -> (WRITE) -> DONE.
//
// Handshake: while in IDLE, exe_flag=1 latches cmd_op/cmd_args. exe_flag is
// ignored in every other state. ready_flag is a one-cycle registered pulse
// that follows DONE. jmp_flag is meaningful only while ready_flag is high.
// A command that is still held on exe_flag during the ready cycle is accepted
// again.
//
// Optional build macro: EXEC_SIGNED_CMP_EN makes CMP's above/below flags use
// signed compares. Without it they use unsigned compares.
module exec_core_param #(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_SIZE  = 32,
  parameter int REG_COUNT  = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int DUMP_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            exe_flag,
  input  logic [3:0]                      cmd_op,
  input  logic [3*WORD_SIZE-1:0]          cmd_args,
  output logic                            ready_flag,
  output logic                            jmp_flag,
  output logic [ADDR_SIZE-1:0]            new_exe_addr_offset,
  output logic                            illegal_flag,
  output logic [DUMP_WORDS*WORD_SIZE-1:0] dump
);

  localparam int RI = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int MI = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [3:0] OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2,
                         OP_SUB = 4'h3, OP_AND = 4'h4, OP_OR  = 4'h5,
                         OP_XOR = 4'h6, OP_CMP = 4'h7, OP_JMP = 4'h8,
                         OP_JE  = 4'h9, OP_JNE = 4'hA, OP_JA  = 4'hB,
                         OP_JB  = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [3*WORD_SIZE-1:0] args_q, args_d;
  logic [WORD_SIZE-1:0]   regs_q [REG_COUNT];
  logic [WORD_SIZE-1:0]   regs_d [REG_COUNT];
  logic [WORD_SIZE-1:0]   mem_q  [MEM_DEPTH];
  logic [WORD_SIZE-1:0]   mem_d  [MEM_DEPTH];
  logic                   eq_q, eq_d, a_q, a_d, b_q, b_d;
  logic                   taken_q, taken_d;
  logic                   wr_mem_q, wr_mem_d;
  logic [RI-1:0]          wr_ridx_q, wr_ridx_d;
  logic [MI-1:0]          wr_maddr_q, wr_maddr_d;
  logic [WORD_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                   ready_q, ready_d;
  logic                   jmp_q, jmp_d;
  logic                   illegal_q, illegal_d;

  // Argument words of the latched command.
  logic [WORD_SIZE-1:0] w0, w1, w2;
  assign w0 = args_q[WORD_SIZE-1:0];
  assign w1 = args_q[2*WORD_SIZE-1:WORD_SIZE];
  assign w2 = args_q[3*WORD_SIZE-1:2*WORD_SIZE];

  // Not every argument bit is meaningful for every opcode.
  logic unused_args;
  assign unused_args = ^args_q;

  // Operand decode. All reads see pre-command state because the
  // register file and RAM only change in WRITE.
  logic [RI-1:0]        ra_idx, rb_idx, rd_idx, src_idx;
  logic [WORD_SIZE-1:0] ra_val, rb_val, src_val, mov_val, alu_val;
  logic [MI-1:0]        mov_dst_addr;
  logic                 is_write_op;

  // Operand fetch, ALU result and MOV source/destination selection.
  always_comb begin
    ra_idx  = w0[8 +: RI];
    rb_idx  = w0[16 +: RI];
    rd_idx  = w0[24 +: RI];
    src_idx = w0[20 +: RI];
    ra_val  = regs_q[ra_idx];
    rb_val  = regs_q[rb_idx];
    src_val = regs_q[src_idx];
    case ({w0[29], w0[28]})
      2'b00:   mov_val = src_val;
      2'b01:   mov_val = w2;
      2'b10:   mov_val = mem_q[src_val[MI-1:0]];
      default: mov_val = mem_q[w2[MI-1:0]];
    endcase
    mov_dst_addr = w0[16] ? w1[MI-1:0] : ra_val[MI-1:0];
    case (op_q)
      OP_ADD:  alu_val = ra_val + rb_val;
      OP_SUB:  alu_val = ra_val - rb_val;
      OP_AND:  alu_val = ra_val & rb_val;
      OP_OR:   alu_val = ra_val | rb_val;
      default: alu_val = ra_val ^ rb_val;
    endcase
    is_write_op = (op_q >= OP_MOV) && (op_q <= OP_XOR);
  end

  // Next-state and control: the command FSM plus its write buffer and flags.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    args_d     = args_q;
    eq_d       = eq_q;
    a_d        = a_q;
    b_d        = b_q;
    taken_d    = taken_q;
    wr_mem_d   = wr_mem_q;
    wr_ridx_d  = wr_ridx_q;
    wr_maddr_d = wr_maddr_q;
    wr_data_d  = wr_data_q;
    ready_d    = 1'b0;
    jmp_d      = 1'b0;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (exe_flag) begin
          op_d    = cmd_op;
          args_d  = cmd_args;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        taken_d = 1'b0;
        case (op_q)
          OP_NOP: ;
          OP_MOV: begin
            wr_mem_d   = w0[17];
            wr_ridx_d  = ra_idx;
            wr_maddr_d = mov_dst_addr;
            wr_data_d  = mov_val;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            wr_mem_d  = 1'b0;
            wr_ridx_d = rd_idx;
            wr_data_d = alu_val;
          end
          OP_CMP: begin
            eq_d = (ra_val == rb_val);
`ifdef EXEC_SIGNED_CMP_EN
            a_d  = ($signed(ra_val) > $signed(rb_val));
            b_d  = ($signed(ra_val) < $signed(rb_val));
`else
            a_d  = (ra_val > rb_val);
            b_d  = (ra_val < rb_val);
`endif
          end
          OP_JMP: taken_d = 1'b1;
          OP_JE:  taken_d = eq_q;
          OP_JNE: taken_d = !eq_q;
          OP_JA:  taken_d = a_q;
          OP_JB:  taken_d = b_q;
          default: illegal_d = 1'b1;
        endcase
        state_d = is_write_op ? S_WRITE : S_DONE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        ready_d = 1'b1;
        jmp_d   = taken_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The single buffered write lands in the register file or RAM during WRITE.
  always_comb begin
    regs_d = regs_q;
    mem_d  = mem_q;
    if (state_q == S_WRITE) begin
      if (wr_mem_q) mem_d[wr_maddr_q] = wr_data_q;
      else          regs_d[wr_ridx_q] = wr_data_q;
    end
  end

  // Control, latched command, flags and write-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      args_q     <= '0;
      eq_q       <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      taken_q    <= 1'b0;
      wr_mem_q   <= 1'b0;
      wr_ridx_q  <= '0;
      wr_maddr_q <= '0;
      wr_data_q  <= '0;
      ready_q    <= 1'b0;
      jmp_q      <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      args_q     <= args_d;
      eq_q       <= eq_d;
      a_q        <= a_d;
      b_q        <= b_d;
      taken_q    <= taken_d;
      wr_mem_q   <= wr_mem_d;
      wr_ridx_q  <= wr_ridx_d;
      wr_maddr_q <= wr_maddr_d;
      wr_data_q  <= wr_data_d;
      ready_q    <= ready_d;
      jmp_q      <= jmp_d;
      illegal_q  <= illegal_d;
    end
  end

  // Architectural storage: register file and data RAM, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      for (int j = 0; j < MEM_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      regs_q <= regs_d;
      mem_q  <= mem_d;
    end
  end

  assign ready_flag          = ready_q;
  assign jmp_flag            = jmp_q;
  assign illegal_flag        = illegal_q;
  assign new_exe_addr_offset = w1[ADDR_SIZE-1:0];

  for (genvar g = 0; g < DUMP_WORDS; g++) begin : g_dump
    assign dump[g*WORD_SIZE +: WORD_SIZE] = mem_q[g];
  end

endmodule
